lstm_pingpong_bram: RTL

- Two-bank (ping-pong) buffer for LSTM activation and weight vectors.
- An upstream producer fills one bank of MEM_SIZE words while the downstream consumer reads the other, previously filled bank.
- Each bank tracks its own fill count and EMPTY/FULL state, and banks swap automatically.
- Removes the stall between consecutive timesteps that a single-bank fill/read buffer imposes.

---
 rtl/lstm_pingpong_bram_if.sv | 35 +++
 rtl/lstm_pingpong_bram.sv | 110 +++++++++++
 2 files changed

// File: rtl/lstm_pingpong_bram_if.sv
// Producer/consumer bus of the two-bank LSTM vector buffer.
// The master side drives strobes, addresses and write data. The slave side is the buffer.
interface lstm_pingpong_bram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  clear;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_ready;
    logic                  fill_done;
    logic                  rd_avail;
    logic                  re;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  rd_release;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] fill_count;
    logic                  addr_err;

    modport master (
        output clear, wr_en, wr_addr, din, re, rd_addr, rd_release,
        input  wr_ready, fill_done, rd_avail, dout, dout_valid,
               wr_bank, rd_bank, fill_count, addr_err
    );

    modport slave (
        input  clear, wr_en, wr_addr, din, re, rd_addr, rd_release,
        output wr_ready, fill_done, rd_avail, dout, dout_valid,
               wr_bank, rd_bank, fill_count, addr_err
    );
endinterface

// File: rtl/lstm_pingpong_bram.sv
// Ping-pong buffer: the producer fills one bank while the consumer reads the other full bank.
// Define LSTM_BRAM_OUTREG_EN to add an output register, which gives a 2-cycle read latency.
module lstm_pingpong_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    lstm_pingpong_bram_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE - 1);
`ifdef LSTM_BRAM_OUTREG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [DATA_WIDTH-1:0] mem [0:1][0:MEM_SIZE-1];

    logic [1:0]            full;
    logic                  wr_bank_q, rd_bank_q;
    logic [ADDR_WIDTH-1:0] fill_q;
    logic                  fill_done_q, addr_err_q;
    logic [STAGES-1:0]     vld_q;
    logic [STAGES:0]       vld_pipe;
    logic [DATA_WIDTH-1:0] dout_q, rd_data;

    logic wr_ready, rd_avail, run;
    logic wr_try, wr_in, wr_ok, wr_last;
    logic rd_ok, rd_in, rel_ok;

    assign run      = rst_n && !bus.clear;
    assign wr_ready = ~full[wr_bank_q];
    assign rd_avail = full[rd_bank_q];
    assign wr_try   = bus.wr_en && wr_ready;
    assign wr_in    = bus.wr_addr <= LAST;
    assign wr_ok    = run && wr_try && wr_in;
    assign wr_last  = wr_ok && (fill_q == LAST);
    assign rd_ok    = bus.re && rd_avail;
    assign rd_in    = bus.rd_addr <= LAST;
    assign rel_ok   = bus.rd_release && rd_avail;
    assign rd_data  = rd_in ? mem[rd_bank_q][bus.rd_addr] : '0;
    assign vld_pipe = {vld_q, rd_ok};

    // The memory has no reset, so reset and clear keep its contents.
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_bank_q][bus.wr_addr] <= bus.din;

`ifdef LSTM_BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] rd_q;
    // Data is latched from the bank selected at acceptance, so a following release cannot redirect it.
    always_ff @(posedge clk)
        if (rd_ok) rd_q <= rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full        <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            fill_q      <= '0;
            fill_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            vld_q       <= '0;
            dout_q      <= '0;
        end else if (bus.clear) begin
            full        <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            fill_q      <= '0;
            fill_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            vld_q       <= '0;
        end else begin
            fill_done_q <= wr_last;
            vld_q       <= vld_pipe[STAGES-1:0];
            if (wr_ok) begin
                if (wr_last) begin
                    full[wr_bank_q] <= 1'b1;
                    wr_bank_q       <= ~wr_bank_q;
                    fill_q          <= '0;
                end else begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            // The writer owns an EMPTY bank and the releaser owns a FULL bank, so these never target the same bit.
            if (rel_ok) begin
                full[rd_bank_q] <= 1'b0;
                rd_bank_q       <= ~rd_bank_q;
            end
            if ((wr_try && !wr_in) || (rd_ok && !rd_in)) addr_err_q <= 1'b1;
`ifdef LSTM_BRAM_OUTREG_EN
            if (vld_pipe[1]) dout_q <= rd_q;
`else
            if (rd_ok) dout_q <= rd_data;
`endif
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.rd_avail   = rd_avail;
    assign bus.fill_done  = fill_done_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_pipe[STAGES];
    assign bus.wr_bank    = wr_bank_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.fill_count = fill_q;
    assign bus.addr_err   = addr_err_q;
endmodule
